// File: rtl/rs232_in_packer.sv
// rs232_in_packer
//   Bulk-IN packet scheduler. Drains 72-bit records from the RS-232 status
//   FIFO, writes the low 64 bits of each record MSB-first as 8 bytes into the
//   usb2_top IN buffer, and commits a packet when it holds MAX_RECORDS
//   records, when the idle timer expires, or when capture is disabled.
//
// Ports
//   clk_50             in   single clock for all logic
//   reset_n            in   synchronous active-low reset
//   enable             in   capture enable; low flushes a partial packet
//   usb_configured     in   a new packet may start only while high
//   fifo_empty         in   status FIFO empty
//   fifo_q[71:0]       in   FIFO read data, valid the cycle after fifo_rden
//   fifo_rden          out  one-cycle FIFO read pulse
//   buf_in_ready       in   IN buffer free (asynchronous)
//   buf_in_commit_ack  in   commit acknowledge (asynchronous)
//   buf_in_addr[8:0]   out  byte address in the IN buffer
//   buf_in_data[7:0]   out  byte data
//   buf_in_wren        out  byte write strobe
//   buf_in_commit      out  commit request, held until acknowledged
//   buf_in_commit_len  out  committed length in bytes
//   busy               out  high whenever the scheduler is not idle
//   pkt_count[15:0]    out  completed packets, wrapping
//
// All outputs are registered, so each strobe appears one cycle after the
// state decision that requests it. The FIFO read therefore takes two internal
// states: RD carries the rden pulse, LD captures fifo_q and presents byte 0.
module rs232_in_packer #(
    parameter int MAX_RECORDS = 64,
    parameter int TIMEOUT     = 50000,
    parameter int TO_W        = 16
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        usb_configured,
    input  logic        fifo_empty,
    input  logic [71:0] fifo_q,
    output logic        fifo_rden,
    input  logic        buf_in_ready,
    input  logic        buf_in_commit_ack,
    output logic [8:0]  buf_in_addr,
    output logic [7:0]  buf_in_data,
    output logic        buf_in_wren,
    output logic        buf_in_commit,
    output logic [9:0]  buf_in_commit_len,
    output logic        busy,
    output logic [15:0] pkt_count
);

    localparam logic [6:0]      MAX_REC_C   = 7'(MAX_RECORDS);
    localparam logic [TO_W-1:0] TIMEOUT_C   = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TIMER_MAX_C = {TO_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_LD     = 3'd2,
        ST_WR     = 3'd3,
        ST_NEXT   = 3'd4,
        ST_COMMIT = 3'd5,
        ST_ACKLO  = 3'd6
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic            rdy_meta_r;
    logic            rdy_sync_r;
    logic            ack_meta_r;
    logic            ack_sync_r;
    logic [63:0]     rec_r;
    logic [6:0]      rec_cnt_r;
    logic [2:0]      byte_idx_r;
    logic [2:0]      nxt_idx_s;
    logic [TO_W-1:0] timer_r;
    logic            start_s;
    logic            fifo_rden_r;
    logic            buf_in_wren_r;
    logic [8:0]      buf_in_addr_r;
    logic [7:0]      buf_in_data_r;
    logic            buf_in_commit_r;
    logic [9:0]      buf_in_commit_len_r;
    logic            busy_r;
    logic [15:0]     pkt_count_r;
    logic            rden_s;
    logic            wren_s;
    logic [8:0]      addr_s;
    logic [7:0]      data_s;
    logic            commit_s;
    logic [9:0]      len_s;
    logic            unused_fifo_tag_s;

    // Byte idx of a record, most significant byte first.
    function automatic logic [7:0] record_byte(input logic [63:0] rec, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = rec[63:56];
            3'd1:    b = rec[55:48];
            3'd2:    b = rec[47:40];
            3'd3:    b = rec[39:32];
            3'd4:    b = rec[31:24];
            3'd5:    b = rec[23:16];
            3'd6:    b = rec[15:8];
            3'd7:    b = rec[7:0];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    // The FIFO tag byte is never forwarded to the host.
    assign unused_fifo_tag_s = ^fifo_q[71:64];

    assign start_s   = enable & usb_configured & rdy_sync_r & ~fifo_empty;
    assign nxt_idx_s = byte_idx_r + 3'd1;

    // Two-flop synchronisers for the asynchronous buffer handshake inputs.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            rdy_meta_r <= 1'b0;
            rdy_sync_r <= 1'b0;
            ack_meta_r <= 1'b0;
            ack_sync_r <= 1'b0;
        end else begin
            rdy_meta_r <= buf_in_ready;
            rdy_sync_r <= rdy_meta_r;
            ack_meta_r <= buf_in_commit_ack;
            ack_sync_r <= ack_meta_r;
        end
    end

    // State register.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decision; NEXT priority is full, flush, more data, timeout.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) next_state_s = ST_RD;
                else         next_state_s = ST_IDLE;
            end
            ST_RD:   next_state_s = ST_LD;
            ST_LD:   next_state_s = ST_WR;
            ST_WR: begin
                if (byte_idx_r == 3'd7) next_state_s = ST_NEXT;
                else                    next_state_s = ST_WR;
            end
            ST_NEXT: begin
                if (rec_cnt_r == MAX_REC_C)   next_state_s = ST_COMMIT;
                else if (!enable)             next_state_s = ST_COMMIT;
                else if (!fifo_empty)         next_state_s = ST_RD;
                else if (timer_r >= TIMEOUT_C) next_state_s = ST_COMMIT;
                else                          next_state_s = ST_NEXT;
            end
            ST_COMMIT: begin
                if (ack_sync_r) next_state_s = ST_ACKLO;
                else            next_state_s = ST_COMMIT;
            end
            ST_ACKLO: begin
                if (!ack_sync_r) next_state_s = ST_IDLE;
                else             next_state_s = ST_ACKLO;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        rden_s   = 1'b0;
        wren_s   = 1'b0;
        addr_s   = 9'd0;
        data_s   = 8'd0;
        commit_s = 1'b0;
        len_s    = buf_in_commit_len_r;
        case (state_r)
            ST_IDLE, ST_NEXT: begin
                if (next_state_s == ST_RD) begin
                    rden_s = 1'b1;
                end else if (next_state_s == ST_COMMIT) begin
                    commit_s = 1'b1;
                    len_s    = {rec_cnt_r, 3'b000};
                end else begin
                    rden_s = 1'b0;
                end
            end
            ST_LD: begin
                // fifo_q is valid now; byte 0 goes straight to the bus.
                wren_s = 1'b1;
                addr_s = {rec_cnt_r[5:0], 3'd0};
                data_s = fifo_q[63:56];
            end
            ST_WR: begin
                if (byte_idx_r != 3'd7) begin
                    wren_s = 1'b1;
                    addr_s = {rec_cnt_r[5:0], nxt_idx_s};
                    data_s = record_byte(rec_r, nxt_idx_s);
                end else begin
                    wren_s = 1'b0;
                end
            end
            ST_COMMIT: commit_s = (next_state_s == ST_COMMIT);
            default:   commit_s = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            fifo_rden_r         <= 1'b0;
            buf_in_wren_r       <= 1'b0;
            buf_in_addr_r       <= 9'd0;
            buf_in_data_r       <= 8'd0;
            buf_in_commit_r     <= 1'b0;
            buf_in_commit_len_r <= 10'd0;
            busy_r              <= 1'b0;
        end else begin
            fifo_rden_r         <= rden_s;
            buf_in_wren_r       <= wren_s;
            buf_in_addr_r       <= addr_s;
            buf_in_data_r       <= data_s;
            buf_in_commit_r     <= commit_s;
            buf_in_commit_len_r <= len_s;
            busy_r              <= (next_state_s != ST_IDLE);
        end
    end

    // Record holding register and byte index within the record.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            rec_r      <= 64'd0;
            byte_idx_r <= 3'd0;
        end else if (state_r == ST_LD) begin
            rec_r      <= fifo_q[63:0];
            byte_idx_r <= 3'd0;
        end else if (state_r == ST_WR) begin
            byte_idx_r <= nxt_idx_s;
        end
    end

    // Record count in the current packet.
    always_ff @(posedge clk_50) begin
        if (!reset_n || state_r == ST_IDLE) begin
            rec_cnt_r <= 7'd0;
        end else if (state_r == ST_WR && byte_idx_r == 3'd7) begin
            rec_cnt_r <= rec_cnt_r + 7'd1;
        end
    end

    // Packet age timer: zero in the cycle after the first read, saturating.
    always_ff @(posedge clk_50) begin
        if (!reset_n || state_r == ST_IDLE || (state_r == ST_RD && rec_cnt_r == 7'd0)) begin
            timer_r <= {TO_W{1'b0}};
        end else if (timer_r != TIMER_MAX_C) begin
            timer_r <= timer_r + {{(TO_W-1){1'b0}}, 1'b1};
        end
    end

    // Completed packet counter, bumped once the acknowledge has dropped.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            pkt_count_r <= 16'd0;
        end else if (state_r == ST_ACKLO && !ack_sync_r) begin
            pkt_count_r <= pkt_count_r + 16'd1;
        end
    end

    assign fifo_rden         = fifo_rden_r;
    assign buf_in_wren       = buf_in_wren_r;
    assign buf_in_addr       = buf_in_addr_r;
    assign buf_in_data       = buf_in_data_r;
    assign buf_in_commit     = buf_in_commit_r;
    assign buf_in_commit_len = buf_in_commit_len_r;
    assign busy              = busy_r;
    assign pkt_count         = pkt_count_r;

endmodule
